serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 115 +++++++++++
 tb/tb_serial_add_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell handles one operand bit per
// clock, LSB first. It produces {cout,sum} = a + b + cin and the signed overflow flag.

module sac_fa_cell (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ c;
  assign co = (x & y) | (x & c) | (y & c);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   opa_q, opb_q;
  logic [WIDTH-2:0]   res_q;       // partial result; the newest bit is added at the MSB
  logic               carry_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q, cout_q, ovf_q;
  logic [WIDTH-1:0]   sum_q;

  logic               s_d, co_d;
  logic [WIDTH-1:0]   res_d;

  sac_fa_cell u_cell (
    .x  (opa_q[0]),
    .y  (opb_q[0]),
    .c  (carry_q),
    .s  (s_d),
    .co (co_d)
  );

  assign res_d = {s_d, res_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            opa_q   <= a;
            opb_q   <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          res_q   <= res_d[WIDTH-1:1];
          opa_q   <= {1'b0, opa_q[WIDTH-1:1]};
          opb_q   <= {1'b0, opb_q[WIDTH-1:1]};
          carry_q <= co_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            // carry_q is still the carry into the MSB here, so ovf comes straight from it
            sum_q   <= res_d;
            cout_q  <= co_d;
            ovf_q   <= carry_q ^ co_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus random bench for serial_add_ctrl (WIDTH=8). Its model is plain
// integer addition with a sign-rule overflow check.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int ncmp = 0;
  int nerr = 0;

  logic [W-1:0] m_sum;
  logic         m_cout, m_ovf;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    assert (act === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    int unsigned full;
    full   = int'(ta) + int'(tb) + int'(tc);
    m_sum  = full[W-1:0];
    m_cout = full[W];
    m_ovf  = (ta[W-1] == tb[W-1]) && (m_sum[W-1] != ta[W-1]);
  endtask

  // Drive one operation from a negedge and check busy/hold/done timing and the result.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input bit disturb);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      check("busy_run", busy, 1'b1);
      check("done_run", done, 1'b0);
      check("sum_hold", sum, m_sum);
      if (disturb && i == 1) begin start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b1; end
      if (disturb && i == 2) begin start = 1'b0; a = W'($urandom); b = W'($urandom); end
      @(posedge clk); @(negedge clk);
    end
    model(ta, tb, tc);
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("sum", sum, m_sum);
    check("cout", cout, m_cout);
    check("ovf", ovf, m_ovf);
    @(posedge clk); @(negedge clk);
    check("done_clear", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("sum_keep", sum, m_sum);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    check("5A+3C_sum", sum, 8'h96);
    check("5A+3C_ovf", ovf, 1'b1);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    check("FF+01_cout", cout, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    check("FF+FF+1_sum", sum, 8'hFF);
    do_op(8'h80, 8'h80, 1'b0, 1'b0);
    check("80+80_ovf", ovf, 1'b1);

    // a start during RUN must be ignored
    do_op(8'h5A, 8'h3C, 1'b0, 1'b1);
    check("ignored_start_sum", sum, 8'h96);

    // start held high: back-to-back, then reset in the middle of the second run
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < W; i++) begin
      check("held_busy", busy, 1'b1);
      @(posedge clk); @(negedge clk);
    end
    check("held_done", done, 1'b1);
    check("held_sum", sum, 8'h30);
    check("held_cout", cout, 1'b0);
    check("held_ovf", ovf, 1'b0);
    @(posedge clk); @(negedge clk);
    check("b2b_busy", busy, 1'b1);
    check("b2b_done", done, 1'b0);
    check("b2b_sum_hold", sum, 8'h30);
    for (int i = 0; i < 3; i++) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0; start = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_sum", sum, 8'h00);
    check("mid_rst_cout", cout, 1'b0);
    check("mid_rst_ovf", ovf, 1'b0);
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    do_op(8'h01, 8'h01, 1'b0, 1'b0);
    check("post_rst_sum", sum, 8'h02);

    for (int n = 0; n < 30; n++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), bit'(n % 7 == 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
